seq_mult_core: RTL and testbench
================================

Name: seq_mult_core

Overview:
- Parametrised sequential shift-add multiplier: WIDTH x WIDTH operands produce a 2*WIDTH-bit product.
- Adds three modes: a runtime signed/unsigned mode, an optional early-exit mode, and an operand-lock indication.
- Sits behind the operand input bus. While `locked` is high, the bus driver tristates `a`/`b`. The product and `done` feed the display/result path.
- Successor to the fixed 8-bit unsigned multiplier.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product width is 2*WIDTH.
- EARLY_EXIT, 0, 1 = terminate the calculation once the remaining multiplier bits are all zero; 0 = fixed latency.

Ports:
- clk  in  1  clock, rising-edge active.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; level-sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands; latched with the operands.
- a  in  WIDTH  multiplicand; sampled only on the accepting edge.
- b  in  WIDTH  multiplier; sampled only on the accepting edge.
- product  out  2*WIDTH  result; held until the next completion.
- done  out  1  one-cycle pulse when `product` is updated.
- locked  out  1  high while operands are captured and the calculation is in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - `product`=0, `done`=0, `locked`=0.
  - All internal registers (accumulator, shift registers, counter, sign flag) are cleared.
  - Any in-flight operation is discarded and no `done` is produced for it.
- States: IDLE, CALC, DONE. Each is held for whole clock cycles.
- IDLE:
  - If `start`=1 at an edge, capture |a| into `mcand` and |b| into `mplier`. Magnitudes are taken only when `signed_mode`=1; otherwise the raw values are used.
  - On the same edge: capture `neg` = signed_mode & (a[MSB]^b[MSB]), clear the accumulator, set the counter to 0, go to CALC, set `locked`=1.
  - The magnitude of the most-negative value (e.g. -128 for WIDTH=8) is represented as unsigned 2^(WIDTH-1) in WIDTH bits.
- CALC, per edge:
  - If `mplier[0]`, add `mcand` shifted left by the counter into a 2*WIDTH-bit accumulator.
  - Shift `mplier` right by 1 and increment the counter.
  - Exit to DONE when counter == WIDTH-1, or when EARLY_EXIT=1 and (`mplier`>>1) == 0.
  - So CALC lasts k cycles: k = WIDTH if EARLY_EXIT=0; k = max(1, index of the highest set bit of |b| + 1) if EARLY_EXIT=1.
- Entering DONE, on the exit edge:
  - `product` = `neg` ? -acc : acc, truncated to 2*WIDTH bits.
  - `done`=1 and `locked`=0.
- DONE:
  - `done` deasserts at the next edge; the state returns to IDLE unconditionally.
  - `start` is ignored in DONE.
- Latency: `done` is high on the cycle following the (k+1)th edge counted from the accepting edge. Fixed mode gives WIDTH+1 edges, i.e. 9 for WIDTH=8. Throughput is one operation per k+2 cycles while `start` is held high.
- `start` asserted in CALC or DONE is ignored, not queued. Operand changes while `locked`=1 have no effect.
- `product` is never modified except on the exit edge or by reset; `done` is never high for two consecutive cycles.
- Unsigned mode is exact for all 2^(2*WIDTH) operand pairs. Signed mode is exact for all pairs, including (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).

Decomposition:
- Package `seq_mult_pkg`:
  - state enum (IDLE, CALC, DONE);
  - counter-width function (clog2 of WIDTH);
  - a localparam for product width.
- One sub-module, `mult_sign_fix`: combinational, parametrised by width. It performs conditional two's-complement negation and is instantiated for operand magnitude (WIDTH) and for result correction (2*WIDTH).

Test Plan:
1. WIDTH=8, EARLY_EXIT=0, unsigned: a=0x81, b=0x13, `start` pulse.
   - `locked`=1 for 8 cycles.
   - `done` rises 9 edges after acceptance with `product`=0x0993 (2451).
   - `done` is high for exactly 1 cycle.
2. Signed mode: (-128)*(-128) must give `product`=0x4000, (-1)*127 must give 0xFF81, and 0*(-5) must give 0x0000, each with `done` asserted.
3. EARLY_EXIT=1, unsigned:
   - b=0x01 must give `done` 2 edges after acceptance.
   - b=0x80 must give `done` 9 edges after acceptance.
   - b=0x00 must give `product`=0 after 2 edges.
4. Change a/b and pulse `start` mid-CALC:
   - `product` must match the captured operands.
   - There must be no second `done`, and `locked` must stay high until completion.
5. Pull `rst` low mid-CALC:
   - Outputs must go to 0 immediately (asynchronously).
   - There must be no `done` after release.
   - The next `start` must compute correctly.
6. `start` held high continuously, with random operands at WIDTH=8 and WIDTH=16:
   - Every `done` must match the golden model (a*b, signed per mode).
   - `done` pulses must be spaced k+2 cycles apart.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// ---------------------------------------------------------------
// seq_mult_pkg : shared types and sizing helpers for seq_mult_core
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_PROD_WIDTH = 2 * DEFAULT_WIDTH;

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_sign_fix.sv
// ---------------------------------------------------------------
// mult_sign_fix : conditional two's-complement negation
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mult_sign_fix
  import seq_mult_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  // Negating the most-negative value yields 2^(W-1), read back as unsigned.
  assign result = negate ? (~value + W'(1)) : value;

endmodule

`default_nettype wire

// File: rtl/seq_mult_core.sv
// ---------------------------------------------------------------
// seq_mult_core : sequential shift-add multiplier, signed/unsigned
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int EARLY_EXIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               locked
);

  localparam int              PW   = 2 * WIDTH;
  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    acc_fixed;
  logic             last_step;

  mult_sign_fix #(.W(WIDTH)) u_fix_a (
    .value  (a),
    .negate (signed_mode & a[WIDTH-1]),
    .result (a_mag)
  );

  mult_sign_fix #(.W(WIDTH)) u_fix_b (
    .value  (b),
    .negate (signed_mode & b[WIDTH-1]),
    .result (b_mag)
  );

  // mcand is pre-shifted each step, equivalent to shifting by the counter.
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;
  assign last_step = (cnt == LAST) ||
                     ((EARLY_EXIT != 0) && (mplier[WIDTH-1:1] == '0));

  mult_sign_fix #(.W(PW)) u_fix_p (
    .value  (acc_next),
    .negate (neg),
    .result (acc_fixed)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
      done    <= 1'b0;
      locked  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{(PW-WIDTH){1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            locked <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            product <= acc_fixed;
            done    <= 1'b1;
            locked  <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done   <= 1'b0;
          locked <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_mult_core.sv
// ---------------------------------------------------------------
// tb_seq_mult_core : directed checks of seq_mult_core (W8, W8 early-exit, W16)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_seq_mult_core;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // instance 0: W8 fixed, 1: W8 early-exit, 2: W16 fixed
  logic        start0 = 0, start1 = 0, start2 = 0;
  logic        sm0 = 0, sm1 = 0, sm2 = 0;
  logic [7:0]  a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [15:0] a2 = 0, b2 = 0;
  logic [15:0] prod0, prod1;
  logic [31:0] prod2;
  logic        done0, done1, done2;
  logic        lock0, lock1, lock2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_mult_core #(.WIDTH(8), .EARLY_EXIT(0)) u_w8 (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(sm0), .a(a0), .b(b0),
    .product(prod0), .done(done0), .locked(lock0)
  );

  seq_mult_core #(.WIDTH(8), .EARLY_EXIT(1)) u_w8e (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm1), .a(a1), .b(b1),
    .product(prod1), .done(done1), .locked(lock1)
  );

  seq_mult_core #(.WIDTH(16), .EARLY_EXIT(0)) u_w16 (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2), .a(a2), .b(b2),
    .product(prod2), .done(done2), .locked(lock2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input int d);
    case (d)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_lock(input int d);
    case (d)
      0:       return lock0;
      1:       return lock1;
      default: return lock2;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int d);
    case (d)
      0:       return {16'd0, prod0};
      1:       return {16'd0, prod1};
      default: return prod2;
    endcase
  endfunction

  task automatic set_in(input int d, input logic st, input logic sm,
                        input logic [15:0] av, input logic [15:0] bv);
    case (d)
      0:       begin start0 = st; sm0 = sm; a0 = av[7:0]; b0 = bv[7:0]; end
      1:       begin start1 = st; sm1 = sm; a1 = av[7:0]; b1 = bv[7:0]; end
      default: begin start2 = st; sm2 = sm; a2 = av;      b2 = bv;      end
    endcase
  endtask

  // Golden product: a*b in two's complement when sm, truncated to 2w bits.
  function automatic logic [31:0] model(input int w, input logic sm,
                                        input logic [15:0] av, input logic [15:0] bv);
    longint sa, sb, half, mask;
    half = longint'(1) << (w - 1);
    mask = (longint'(1) << (2 * w)) - 1;
    sa   = longint'(av);
    sb   = longint'(bv);
    if (sm) begin
      sa = (sa ^ half) - half;
      sb = (sb ^ half) - half;
    end
    return 32'((sa * sb) & mask);
  endfunction

  function automatic int calc_cycles(input int w, input bit early, input logic sm,
                                     input logic [15:0] bv);
    longint mag;
    int k;
    if (!early) return w;
    mag = longint'(bv);
    if (sm && bv[w-1]) mag = (longint'(1) << w) - mag;
    k = 1;
    for (int i = 0; i < w; i++)
      if (mag[i]) k = i + 1;
    return k;
  endfunction

  // edges counts the accepting edge as 1; done is expected after edge k+1.
  task automatic run_op(input int d, input logic sm, input logic [15:0] av,
                        input logic [15:0] bv, input logic [31:0] exp_p,
                        input int exp_edges, input string tag);
    int edges;
    int lk;
    @(negedge clk);
    set_in(d, 1'b1, sm, av, bv);
    @(posedge clk); #1;
    set_in(d, 1'b0, sm, av, bv);
    edges = 1;
    lk    = 0;
    while (!get_done(d) && edges < 64) begin
      if (get_lock(d)) lk++;
      @(posedge clk); #1;
      edges++;
    end
    check_val({tag, "_edges"}, 32'(edges), 32'(exp_edges));
    check_val({tag, "_prod"}, get_prod(d), exp_p);
    check_val({tag, "_lockcyc"}, 32'(lk), 32'(exp_edges - 1));
    check_val({tag, "_unlock"}, {31'd0, get_lock(d)}, 32'd0);
    @(posedge clk); #1;
    check_val({tag, "_donepulse"}, {31'd0, get_done(d)}, 32'd0);
  endtask

  // start held high: each done checked against the model and for k+2 spacing.
  task automatic stream(input int d, input int w, input bit early, input logic sm,
                        input int n, input string tag);
    logic [15:0] av, bv, mask;
    int e, last, cnt, k;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    av   = 16'($urandom) & mask;
    bv   = 16'($urandom) & mask;
    @(negedge clk);
    set_in(d, 1'b1, sm, av, bv);
    e = 0; last = -1; cnt = 0;
    while (cnt < n && e < 500) begin
      @(posedge clk); #1;
      e++;
      if (get_done(d)) begin
        k = calc_cycles(w, early, sm, bv);
        check_val({tag, "_prod"}, get_prod(d), model(w, sm, av, bv));
        if (last >= 0) check_val({tag, "_gap"}, 32'(e - last), 32'(k + 2));
        last = e;
        cnt++;
        av = 16'($urandom) & mask;
        bv = 16'($urandom) & mask;
        if (cnt == 2) bv = 16'h0001 & mask;
        set_in(d, (cnt < n), sm, av, bv);
      end
    end
    set_in(d, 1'b0, sm, av, bv);
    check_val({tag, "_count"}, 32'(cnt), 32'(n));
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int ndone, lk, first;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_prod0", get_prod(0), 32'd0);
    check_val("rst_prod2", get_prod(2), 32'd0);
    check_val("rst_ctl", {29'd0, done0 | done1 | done2, lock0 | lock1, lock2}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // fixed latency, unsigned: 0x81*0x13 = 2451
    run_op(0, 1'b0, 16'h0081, 16'h0013, 32'h0993, 9, "u8_basic");
    run_op(0, 1'b0, 16'h00FF, 16'h00FF, 32'hFE01, 9, "u8_max");

    // signed corners
    run_op(0, 1'b1, 16'h0080, 16'h0080, 32'h4000, 9, "s8_minmin");
    run_op(0, 1'b1, 16'h00FF, 16'h007F, 32'hFF81, 9, "s8_m1x127");
    run_op(0, 1'b1, 16'h0000, 16'h00FB, 32'h0000, 9, "s8_zero");

    // early exit
    run_op(1, 1'b0, 16'h0055, 16'h0001, 32'h0055, 2, "ee_b1");
    run_op(1, 1'b0, 16'h0003, 16'h0080, 32'h0180, 9, "ee_b80");
    run_op(1, 1'b0, 16'h00AB, 16'h0000, 32'h0000, 2, "ee_b0");
    run_op(1, 1'b1, 16'h0005, 16'h00FE, 32'hFFF6, 3, "ee_s5xm2");

    // 16-bit
    run_op(2, 1'b0, 16'h1234, 16'h5678, 32'h06260060, 17, "u16");
    run_op(2, 1'b1, 16'h8000, 16'hFFFF, 32'h00008000, 17, "s16_minxm1");

    // operand and start changes while locked are ignored
    @(negedge clk);
    set_in(0, 1'b1, 1'b0, 16'h000A, 16'h000B);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0, 16'h000A, 16'h000B);
    ndone = 0; lk = 0; first = 0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 3) set_in(0, 1'b1, 1'b1, 16'h00C3, 16'h005A);
      if (e == 6) set_in(0, 1'b0, 1'b1, 16'h00C3, 16'h005A);
      if (get_lock(0)) lk++;
      if (get_done(0)) begin
        ndone++;
        if (first == 0) first = e;
      end
      @(posedge clk); #1;
    end
    check_val("midcalc_prod", get_prod(0), 32'h006E);
    check_val("midcalc_ndone", 32'(ndone), 32'd1);
    check_val("midcalc_first", 32'(first), 32'd9);
    check_val("midcalc_lock", 32'(lk), 32'd8);

    // asynchronous reset mid-calculation
    @(negedge clk);
    set_in(0, 1'b1, 1'b0, 16'h0010, 16'h0010);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0, 16'h0010, 16'h0010);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_val("arst_prod", get_prod(0), 32'd0);
    check_val("arst_lock", {31'd0, get_lock(0)}, 32'd0);
    check_val("arst_done", {31'd0, get_done(0)}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      if (get_done(0)) ndone++;
    end
    check_val("arst_nodone", 32'(ndone), 32'd0);
    run_op(0, 1'b0, 16'h0003, 16'h0005, 32'h000F, 9, "arst_next");

    // back-to-back with start held high
    stream(0, 8, 1'b0, 1'b1, 4, "str_w8s");
    stream(1, 8, 1'b1, 1'b1, 5, "str_w8e");
    stream(2, 16, 1'b0, 1'b1, 4, "str_w16s");
    stream(2, 16, 1'b0, 1'b0, 3, "str_w16u");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
